seg7_scan_capture: RTL and testbench

//  Inverse of the hex->7-seg display path: snoops a multiplexed 7-segment bus (segment lines + digit anodes),

---
 rtl/seg7_pkg.sv | 33 +++
 rtl/seg7_rev_dec.sv | 13 +
 rtl/seg7_scan_capture.sv | 129 ++++++++++++
 tb/tb_seg7_scan_capture.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared definitions for the 7-segment scan capture block: glyph table,
// reverse lookup and the frame FSM state type.
package seg7_pkg;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Active-low {g,f,e,d,c,b,a} glyphs for hex digits 0..F, index = nibble
    localparam logic [0:15][6:0] SEG_GLYPH = {
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0011000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    typedef enum logic {
        ST_COLLECT,
        ST_FULL
    } state_t;

    function automatic logic [4:0] seg_to_nibble(input logic [6:0] seg);
        logic [4:0] res;
        logic [3:0] idx;
        res = {1'b1, 4'h0};
        for (int i = 0; i < 16; i++) begin
            idx = 4'(i);
            if (seg == SEG_GLYPH[idx]) begin
                res = {1'b0, idx};
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/seg7_rev_dec.sv
// Combinational reverse decoder: active-low segment pattern to nibble,
// flagging any pattern that is not a hex glyph.
module seg7_rev_dec
    import seg7_pkg::*;
(
    input  logic [6:0] seg,
    output logic [3:0] nibble,
    output logic       err
);

    assign {err, nibble} = seg_to_nibble(seg);

endmodule

// File: rtl/seg7_scan_capture.sv
// Snoops a multiplexed 7-segment bus, accepts each digit once it has settled,
// and hands complete display words downstream on a valid/ready port.
module seg7_scan_capture
    import seg7_pkg::*;
#(
    parameter int N_DIGITS   = 4,
    parameter int STABLE_CYC = 4,
    parameter int AN_ACT_LOW = 1
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic [6:0]              i_seg,
    input  logic [N_DIGITS-1:0]     i_an,
    output logic [4*N_DIGITS-1:0]   o_dat,
    output logic [N_DIGITS-1:0]     o_err,
    output logic                    o_ovr,
    output logic                    o_valid,
    input  logic                    i_ready
);

    localparam int CW = $clog2(STABLE_CYC + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYC);
    localparam logic [N_DIGITS-1:0] AN_IDLE = (AN_ACT_LOW != 0) ? '1 : '0;

    logic [6:0]                 seg_q, seg_p;
    logic [N_DIGITS-1:0]        an_q, an_p;
    logic [CW-1:0]              cnt, cnt_nxt;
    logic [N_DIGITS-1:0]        an_norm, acc_mask, seen, seen_acc;
    logic                       one_hot, same, accept;
    logic [3:0]                 dec_nib;
    logic                       dec_err;
    logic [N_DIGITS-1:0][3:0]   shadow_dat;
    logic [N_DIGITS-1:0]        shadow_err;
    logic                       ovr_pend;
    state_t                     state;

    assign an_norm  = (AN_ACT_LOW != 0) ? ~an_q : an_q;
    assign one_hot  = (an_norm != '0) && ((an_norm & (an_norm - N_DIGITS'(1))) == '0);
    assign same     = (seg_q == seg_p) && (an_q == an_p);
    assign accept   = one_hot && (cnt_nxt == CNT_MAX) && (cnt != CNT_MAX);
    assign acc_mask = accept ? an_norm : '0;
    assign seen_acc = seen | acc_mask;

    // Run length of the registered (seg, an) pair; an unselected or
    // ambiguous anode vector never counts as a stable digit.
    always_comb begin
        cnt_nxt = '0;
        if (!one_hot) begin
            cnt_nxt = '0;
        end else if (!same) begin
            cnt_nxt = CW'(1);
        end else if (cnt == CNT_MAX) begin
            cnt_nxt = cnt;
        end else begin
            cnt_nxt = cnt + CW'(1);
        end
    end

    seg7_rev_dec u_dec (
        .seg    (seg_q),
        .nibble (dec_nib),
        .err    (dec_err)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            seg_q <= SEG_BLANK;
            seg_p <= SEG_BLANK;
            an_q  <= AN_IDLE;
            an_p  <= AN_IDLE;
            cnt   <= '0;
        end else begin
            seg_q <= i_seg;
            seg_p <= seg_q;
            an_q  <= i_an;
            an_p  <= an_q;
            cnt   <= cnt_nxt;
        end
    end

    // Accepted digits always land in the shadow; the FSM decides whether
    // that is a fresh frame, the pending one, or an overwrite while stalled.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            shadow_dat <= '0;
            shadow_err <= '0;
            seen       <= '0;
            ovr_pend   <= 1'b0;
            state      <= ST_COLLECT;
            o_dat      <= '0;
            o_err      <= '0;
            o_ovr      <= 1'b0;
            o_valid    <= 1'b0;
        end else begin
            for (int k = 0; k < N_DIGITS; k++) begin
                if (acc_mask[k]) begin
                    shadow_dat[k] <= dec_nib;
                    shadow_err[k] <= dec_err;
                end
            end
            case (state)
                ST_COLLECT: begin
                    seen <= seen_acc;
                    if (seen_acc == '1) begin
                        state <= ST_FULL;
                    end
                    if (o_valid && i_ready) begin
                        o_valid <= 1'b0;
                    end
                end
                ST_FULL: begin
                    if (!o_valid || i_ready) begin
                        o_dat    <= shadow_dat;
                        o_err    <= shadow_err;
                        o_ovr    <= ovr_pend;
                        o_valid  <= 1'b1;
                        seen     <= acc_mask;
                        ovr_pend <= 1'b0;
                        state    <= ST_COLLECT;
                    end else begin
                        ovr_pend <= ovr_pend | accept;
                    end
                end
                default: state <= ST_COLLECT;
            endcase
        end
    end

endmodule

// File: tb/tb_seg7_scan_capture.sv
// Directed and randomized bench for seg7_scan_capture against a frame-level
// reference model built from the display-glyph rules.
module tb_seg7_scan_capture;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [6:0]  i_seg;
    logic [3:0]  i_an;
    logic        i_ready;
    logic [15:0] o_dat;
    logic [3:0]  o_err;
    logic        o_ovr;
    logic        o_valid;

    int vectors = 0;
    int miscompares = 0;

    logic [6:0] glyph [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0011000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    // Reference model state: recent input samples plus frame bookkeeping
    logic [10:0] hist [$];
    logic [3:0]  m_seen;
    logic [15:0] m_dat;
    logic [3:0]  m_err;
    bit          m_full, m_pend;
    logic        e_valid, e_ovr;
    logic [15:0] e_dat;
    logic [3:0]  e_err;

    logic [15:0] last_dat;
    logic [3:0]  last_err;
    logic        last_ovr;
    int          valid_cycles;

    seg7_scan_capture #(
        .N_DIGITS   (4),
        .STABLE_CYC (4),
        .AN_ACT_LOW (1)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_seg   (i_seg),
        .i_an    (i_an),
        .o_dat   (o_dat),
        .o_err   (o_err),
        .o_ovr   (o_ovr),
        .o_valid (o_valid),
        .i_ready (i_ready)
    );

    always #5 clk = ~clk;

    function automatic logic [4:0] ref_decode(input logic [6:0] s);
        for (int i = 0; i < 16; i++) begin
            if (glyph[i] == s) return {1'b0, 4'(i)};
        end
        return 5'h10;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        hist.delete();
        hist.push_front({7'h7F, 4'hF});
        m_seen = '0; m_dat = '0; m_err = '0; m_full = 0; m_pend = 0;
        e_valid = 0; e_ovr = 0; e_dat = '0; e_err = '0;
    endtask

    // A digit is taken when the last four samples match, it is a single
    // selected digit, and the run has not already been taken earlier.
    task automatic model_step(input logic [6:0] seg, input logic [3:0] an, input bit rdy);
        logic [10:0] h0;
        bit          acc;
        int          k;
        logic [4:0]  dec;
        logic [3:0]  bitm;
        acc = 0; k = 0; dec = '0; bitm = '0;
        h0 = hist[0];
        if (hist.size() >= 4 && $countones(~h0[3:0]) == 1) begin
            acc = (hist[1] == h0) && (hist[2] == h0) && (hist[3] == h0);
            if (hist.size() >= 5 && hist[4] == h0) acc = 0;
        end
        if (acc) begin
            for (int i = 0; i < 4; i++) if (!h0[i]) k = i;
            dec = ref_decode(h0[10:4]);
            bitm = 4'b0001 << k;
        end
        if (!m_full) begin
            if (acc) begin m_dat[4*k +: 4] = dec[3:0]; m_err[k] = dec[4]; end
            m_seen = m_seen | bitm;
            if (m_seen == 4'hF) m_full = 1;
            if (e_valid && rdy) e_valid = 0;
        end else if (!e_valid || rdy) begin
            e_dat = m_dat; e_err = m_err; e_ovr = m_pend; e_valid = 1;
            m_pend = 0; m_full = 0; m_seen = bitm;
            if (acc) begin m_dat[4*k +: 4] = dec[3:0]; m_err[k] = dec[4]; end
        end else if (acc) begin
            m_dat[4*k +: 4] = dec[3:0]; m_err[k] = dec[4]; m_pend = 1;
        end
        hist.push_front({seg, an});
        if (hist.size() > 5) void'(hist.pop_back());
    endtask

    task automatic check_output();
        check("out", {10'd0, o_valid, o_ovr, o_err, o_dat}, {10'd0, e_valid, e_ovr, e_err, e_dat});
        if (o_valid) begin
            last_dat = o_dat; last_err = o_err; last_ovr = o_ovr;
            valid_cycles++;
        end
    endtask

    task automatic apply_stimulus(input logic [6:0] seg, input logic [3:0] an, input bit rdy);
        i_seg = seg; i_an = an; i_ready = rdy;
        @(posedge clk);
        model_step(seg, an, rdy);
        @(negedge clk);
        check_output();
    endtask

    task automatic drive_raw(input logic [6:0] seg, input logic [3:0] an, input int cyc, input bit rdy);
        for (int c = 0; c < cyc; c++) apply_stimulus(seg, an, rdy);
    endtask

    task automatic show_digit(input int k, input logic [3:0] val, input int cyc, input bit rdy);
        drive_raw(glyph[val], ~(4'b0001 << k), cyc, rdy);
    endtask

    task automatic scan4(input logic [15:0] word, input int cyc, input bit rdy);
        for (int k = 0; k < 4; k++) show_digit(k, word[4*k +: 4], cyc, rdy);
    endtask

    task automatic do_reset();
        i_seg = 7'h7F; i_an = 4'hF; i_ready = 1'b0;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("rst_valid", {31'd0, o_valid}, 32'd0);
        check("rst_dat", {16'd0, o_dat}, 32'd0);
        check("rst_err_ovr", {27'd0, o_err, o_ovr}, 32'd0);
        repeat (2) begin
            @(negedge clk);
            check_output();
        end
        rst_n = 1'b1;
    endtask

    initial begin
        i_seg = 7'h7F; i_an = 4'hF; i_ready = 1'b0; rst_n = 1'b1;
        last_dat = '0; last_err = '0; last_ovr = 0; valid_cycles = 0;
        @(negedge clk);
        do_reset();

        // Plain scan with downstream always ready
        valid_cycles = 0;
        scan4(16'hB0A3, 6, 1'b1);
        drive_raw(7'h7F, 4'hF, 4, 1'b1);
        check("t1_valid_cycles", valid_cycles, 1);
        check("t1_dat", {16'd0, last_dat}, 32'h0000B0A3);
        check("t1_err", {28'd0, last_err}, 32'd0);
        check("t1_ovr", {31'd0, last_ovr}, 32'd0);

        // Digits that never settle long enough, then just long enough
        valid_cycles = 0;
        for (int r = 0; r < 2; r++) scan4(16'h4321, 3, 1'b1);
        drive_raw(7'h7F, 4'hF, 3, 1'b1);
        check("t2_short_hold", valid_cycles, 0);
        scan4(16'hE987, 4, 1'b1);
        drive_raw(7'h7F, 4'hF, 4, 1'b1);
        check("t2_valid_cycles", valid_cycles, 1);
        check("t2_dat", {16'd0, last_dat}, 32'h0000E987);

        // Blank glyph on digit 2
        show_digit(0, 4'h1, 5, 1'b1);
        show_digit(1, 4'h2, 5, 1'b1);
        drive_raw(7'b1111111, 4'b1011, 5, 1'b1);
        show_digit(3, 4'hF, 5, 1'b1);
        drive_raw(7'h7F, 4'hF, 3, 1'b1);
        check("t3_dat", {16'd0, last_dat}, 32'h0000F021);
        check("t3_err", {28'd0, last_err}, 32'h4);

        // Ambiguous anode vectors leave the partial frame untouched
        valid_cycles = 0;
        show_digit(0, 4'h4, 5, 1'b1);
        show_digit(1, 4'h5, 5, 1'b1);
        drive_raw(glyph[9], 4'b1100, 10, 1'b1);
        drive_raw(glyph[9], 4'b1111, 10, 1'b1);
        check("t4_no_frame", valid_cycles, 0);
        show_digit(2, 4'h6, 5, 1'b1);
        show_digit(3, 4'h7, 5, 1'b1);
        drive_raw(7'h7F, 4'hF, 3, 1'b1);
        check("t4_dat", {16'd0, last_dat}, 32'h00007654);
        check("t4_err", {28'd0, last_err}, 32'd0);

        // Stalled downstream: first frame held, later frame overwritten
        scan4(16'h4213, 5, 1'b0);
        scan4(16'h4213, 5, 1'b0);
        scan4(16'h4215, 5, 1'b0);
        drive_raw(7'h7F, 4'hF, 2, 1'b0);
        check("t5_held_valid", {31'd0, o_valid}, 32'd1);
        check("t5_held_dat", {16'd0, o_dat}, 32'h00004213);
        check("t5_held_ovr", {31'd0, o_ovr}, 32'd0);
        apply_stimulus(7'h7F, 4'hF, 1'b1);
        check("t5_b2b_valid", {31'd0, o_valid}, 32'd1);
        check("t5_new_dat", {16'd0, o_dat}, 32'h00004215);
        check("t5_new_ovr", {31'd0, o_ovr}, 32'd1);
        apply_stimulus(7'h7F, 4'hF, 1'b1);
        check("t5_drop_valid", {31'd0, o_valid}, 32'd0);

        // Reset with a held frame and a partial frame in flight
        scan4(16'h4321, 5, 1'b0);
        drive_raw(7'h7F, 4'hF, 2, 1'b0);
        show_digit(0, 4'h8, 5, 1'b0);
        show_digit(1, 4'h9, 5, 1'b0);
        do_reset();
        valid_cycles = 0;
        scan4(16'hDCBA, 5, 1'b1);
        drive_raw(7'h7F, 4'hF, 4, 1'b1);
        check("t6_valid_cycles", valid_cycles, 1);
        check("t6_dat", {16'd0, last_dat}, 32'h0000DCBA);

        // Randomized scanning, glitches and backpressure
        for (int s = 0; s < 80; s++) begin
            int          mode, hold, k;
            logic [6:0]  seg;
            logic [3:0]  an;
            mode = $urandom_range(0, 9);
            k    = $urandom_range(0, 3);
            hold = $urandom_range(1, 7);
            an   = ~(4'b0001 << k);
            seg  = glyph[$urandom_range(0, 15)];
            if (mode == 0) an = 4'($urandom);
            if (mode == 1) seg = 7'($urandom);
            for (int c = 0; c < hold; c++) apply_stimulus(seg, an, $urandom_range(0, 3) != 0);
        end
        drive_raw(7'h7F, 4'hF, 4, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
